// File: rtl/fp_to_int_converter.sv
// fp32 -> int32 converter: unpack, 1-bit-per-cycle alignment shifter, IEEE rounding, saturation.
// Optional inexact flag port enabled by defining FP_CVT_INEXACT_EN.
module fp_to_int_converter (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] fp_in,
   input  logic [2:0]  r_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] int_out,
   output logic        invalid
`ifdef FP_CVT_INEXACT_EN
   ,
   output logic        inexact
`endif
);

   localparam int unsigned W  = 32;
   localparam int unsigned FW = 23;
   localparam int unsigned CW = 5;

   typedef enum logic [1:0] {IDLE, SHIFT, ROUND, OUT} state_t;

   state_t         state, state_d;
   logic           sign_q, sign_d;
   logic [2:0]     rm_q, rm_d;
   logic [W-1:0]   mag_q, mag_d;
   logic           grd_q, grd_d;
   logic           stk_q, stk_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           left_q, left_d;
   logic           sat_q, sat_d;
   logic [W-1:0]   int_d;
   logic           inv_d, out_valid_d, in_ready_d;

   logic [7:0]     ld_exp;
   logic [FW-1:0]  ld_frac;
   logic           ld_sign, ld_stk, ld_left, ld_sat;
   logic [W-1:0]   ld_mag;
   logic [CW-1:0]  ld_cnt;

   logic           inc;
   logic [W:0]     sum;
   logic [W-1:0]   rnd_res;
   logic           rnd_inv;

   // Operand unpack: classify exponent and pick initial magnitude and shift count
   always_comb begin
      ld_exp  = fp_in[30:23];
      ld_frac = fp_in[FW-1:0];
      ld_sign = fp_in[31];
      ld_mag  = '0;
      ld_stk  = 1'b0;
      ld_cnt  = '0;
      ld_left = 1'b0;
      ld_sat  = 1'b0;
      if (ld_exp == 8'd255) begin
         ld_sat = 1'b1;
         if (ld_frac != '0) ld_sign = 1'b0;
      end else if (ld_exp >= 8'd158) begin
         if (ld_sign && ld_exp == 8'd158 && ld_frac == '0) ld_mag = 32'h8000_0000;
         else                                               ld_sat = 1'b1;
      end else if (ld_exp == 8'd0) begin
         ld_stk = |ld_frac;
      end else begin
         ld_mag = {8'd0, 1'b1, ld_frac};
         if (ld_exp >= 8'd150) begin
            ld_left = 1'b1;
            ld_cnt  = CW'(ld_exp - 8'd150);
         end else if (ld_exp <= 8'd125) begin
            ld_cnt  = CW'(25);
         end else begin
            ld_cnt  = CW'(8'd150 - ld_exp);
         end
      end
   end

   // Rounding increment, two's-complement conversion and final saturation
   always_comb begin
      inc = 1'b0;
      case (rm_q)
         3'b000:  inc = grd_q & (stk_q | mag_q[0]);
         3'b010:  inc = sign_q & (grd_q | stk_q);
         3'b011:  inc = ~sign_q & (grd_q | stk_q);
         3'b100:  inc = grd_q;
         default: inc = 1'b0;
      endcase
      sum     = {1'b0, mag_q} + (W+1)'(inc);
      rnd_inv = 1'b1;
      rnd_res = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
      if (!sat_q) begin
         if (!sign_q && sum <= 33'h0_7FFF_FFFF) begin
            rnd_inv = 1'b0;
            rnd_res = sum[W-1:0];
         end else if (sign_q && sum <= 33'h0_8000_0000) begin
            rnd_inv = 1'b0;
            rnd_res = ~sum[W-1:0] + 32'd1;
         end
      end
   end

   always_comb begin
      state_d     = state;
      sign_d      = sign_q;
      rm_d        = rm_q;
      mag_d       = mag_q;
      grd_d       = grd_q;
      stk_d       = stk_q;
      cnt_d       = cnt_q;
      left_d      = left_q;
      sat_d       = sat_q;
      int_d       = int_out;
      inv_d       = invalid;
      out_valid_d = out_valid;
      in_ready_d  = in_ready;
      case (state)
         IDLE: begin
            if (in_valid) begin
               sign_d     = ld_sign;
               rm_d       = r_mode;
               mag_d      = ld_mag;
               grd_d      = 1'b0;
               stk_d      = ld_stk;
               cnt_d      = ld_cnt;
               left_d     = ld_left;
               sat_d      = ld_sat;
               in_ready_d = 1'b0;
               state_d    = (ld_cnt != '0) ? SHIFT : ROUND;
            end
         end
         SHIFT: begin
            if (left_q) begin
               mag_d = mag_q << 1;
            end else begin
               mag_d = mag_q >> 1;
               grd_d = mag_q[0];
               stk_d = stk_q | grd_q;
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = ROUND;
         end
         ROUND: begin
            int_d       = rnd_res;
            inv_d       = rnd_inv;
            out_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sign_q    <= 1'b0;
         rm_q      <= '0;
         mag_q     <= '0;
         grd_q     <= 1'b0;
         stk_q     <= 1'b0;
         cnt_q     <= '0;
         left_q    <= 1'b0;
         sat_q     <= 1'b0;
         int_out   <= '0;
         invalid   <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         state     <= state_d;
         sign_q    <= sign_d;
         rm_q      <= rm_d;
         mag_q     <= mag_d;
         grd_q     <= grd_d;
         stk_q     <= stk_d;
         cnt_q     <= cnt_d;
         left_q    <= left_d;
         sat_q     <= sat_d;
         int_out   <= int_d;
         invalid   <= inv_d;
         out_valid <= out_valid_d;
         in_ready  <= in_ready_d;
      end
   end

`ifdef FP_CVT_INEXACT_EN
   // Inexact is captured alongside the result
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 inexact <= 1'b0;
      else if (state == ROUND) inexact <= (grd_q | stk_q) & ~rnd_inv;
   end
`endif

endmodule
